// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and access-legality helpers for the load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL} err_t;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return we ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == F3_H[1:0] && off[0]) || (f3[1:0] == F3_W[1:0] && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication / byte enables and load lane extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_f3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shift;
    logic [7:0]  w_b;
    logic [15:0] w_h;

    always_comb begin
        o_be    = i_st_f3[1] ? 4'b1111 : i_st_f3[0] ? (i_st_off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << i_st_off;
        o_wdata = i_st_f3[1] ? i_wdata : i_st_f3[0] ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
        w_shift = i_rdata >> {i_ld_off, 3'b000};
        w_b     = w_shift[7:0];
        w_h     = w_shift[15:0];
        // funct3[2] marks the unsigned variants
        o_rdata = i_ld_f3[1] ? i_rdata :
                  i_ld_f3[0] ? {{16{w_h[15] & ~i_ld_f3[2]}}, w_h} : {{24{w_b[7] & ~i_ld_f3[2]}}, w_b};
    end
endmodule

// File: rtl/lsu_dmem.sv
// lsu_dmem: RV32I load/store unit bridging the core datapath to a word-addressed,
// byte-enabled data memory with stall, completion pulse and error reporting.
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int DATA_SIZE = 1024,
    parameter int TIMEOUT   = 16,
    localparam int AW = $clog2(DATA_SIZE)
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    funct3,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          stall,
    output logic          done,
    output logic [31:0]   rdata,
    output logic [1:0]    err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata, r_rdata;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    err_t          r_err;
    logic          w_illegal, w_misalign, w_expire, w_unused;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_ld;

    assign w_illegal  = f3_illegal(req_we, funct3);
    assign w_misalign = f3_misaligned(funct3, addr[1:0]);
    assign w_expire   = r_cnt == LAST;
    assign w_unused   = ^addr[31:AW+2];
    assign mem_we     = r_we;
    assign mem_be     = r_be;
    assign mem_wdata  = r_wdata;
    assign mem_addr   = r_addr;
    assign rdata      = r_rdata;
    assign err        = r_err;

    lsu_align u_align (
        .i_st_f3 (funct3),
        .i_st_off(addr[1:0]),
        .i_wdata (wdata),
        .i_ld_f3 (r_f3),
        .i_ld_off(r_off),
        .i_rdata (mem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_ld)
    );

    always_comb begin
        w_next  = r_state;
        stall   = 1'b0;
        done    = 1'b0;
        mem_req = 1'b0;
        case (r_state)
            IDLE: begin
                w_next = !req_valid ? IDLE : (w_illegal || w_misalign) ? RESP : BUSY;
                stall  = req_valid;
            end
            BUSY: begin
                w_next  = (mem_ack || w_expire) ? RESP : BUSY;
                stall   = 1'b1;
                mem_req = 1'b1;
            end
            default: begin
                w_next = IDLE;
                done   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_f3    <= '0;
            r_off   <= '0;
            r_err   <= ERR_OK;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == BUSY && w_next == BUSY) ? r_cnt + 1'b1 : '0;
            if (r_state == IDLE && req_valid) begin
                if (w_illegal || w_misalign) begin
                    r_err   <= w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                    r_rdata <= '0;
                end else begin
                    r_we    <= req_we;
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                    r_addr  <= addr[AW+1:2];
                    r_f3    <= funct3;
                    r_off   <= addr[1:0];
                end
            end
            // an ack on the expiry cycle still counts as success
            if (r_state == BUSY && (mem_ack || w_expire)) begin
                r_err   <= mem_ack ? ERR_OK : ERR_TIMEOUT;
                r_rdata <= (mem_ack && !r_we) ? w_ld : '0;
            end
        end
    end
endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: randomized scoreboard bench for lsu_dmem against a byte-array reference model.
module tb_lsu_dmem;
    localparam int TO = 16;

    logic        CLK = 0, RESET_N = 0, req_valid = 0, req_we = 0, mem_ack = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
    logic        stall, done, mem_req, mem_we;
    logic [31:0] rdata, mem_wdata;
    logic [1:0]  err;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;

    lsu_dmem #(.DATA_SIZE(1024), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {logic [31:0] rdata; logic [1:0] err; int busy; int issue;} exp_t;
    typedef struct {logic [9:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;} tx_t;

    exp_t        exp_q[$];
    tx_t         tx_q[$];
    int          lat_q[$];
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] dmem [0:1023];
    int          checks = 0, failures = 0, cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the access touches `size` bytes at a byte address inside a 4 KiB memory.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input int lat);
        exp_t e;
        tx_t t;
        int size, ba;
        bit legal;
        logic [31:0] v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        ba = int'(a[11:0]);
        e.rdata = 0;
        e.busy  = 0;
        e.issue = cyc;
        if (!legal) e.err = 2'b11;
        else if (ba % size != 0) e.err = 2'b01;
        else begin
            t.addr = a[11:2];
            t.we   = we;
            t.be   = 4'((1 << size) - 1) << a[1:0];
            for (int i = 0; i < 4; i++) t.wdata[8*i+:8] = wd[8*(i%size)+:8];
            tx_q.push_back(t);
            lat_q.push_back(lat);
            e.busy = lat < TO ? lat + 1 : TO;
            e.err  = lat < TO ? 2'b00 : 2'b10;
            if (lat < TO) begin
                if (we) for (int i = 0; i < size; i++) ref_mem[ba+i] = wd[8*i+:8];
                else begin
                    v = 0;
                    for (int i = 0; i < size; i++) v[8*i+:8] = ref_mem[ba+i];
                    if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                    e.rdata = v;
                end
            end
        end
        exp_q.push_back(e);
        req_valid = 1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            if (done) break;
            n++;
            if (n > 100) begin
                failures++;
                $display("FAIL done_timeout actual=no_done required=done t=%0t", $time);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // Memory responder: acks the Nth BUSY cycle of each transaction, N taken from lat_q.
    bit act = 0;
    int k = 0, l = 0;
    always @(negedge CLK) begin
        if (!RESET_N) begin
            act = 0;
            mem_ack = 0;
        end else if (mem_req) begin
            if (!act) begin
                act = 1;
                k = 0;
                if (lat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_req actual=1 required=0 t=%0t", $time);
                    l = 0;
                end else l = lat_q.pop_front();
            end
            mem_ack = (k == l);
            mem_rdata = mem_ack ? dmem[mem_addr] : $urandom;
            if (mem_ack && mem_we)
                for (int i = 0; i < 4; i++) if (mem_be[i]) dmem[mem_addr][8*i+:8] = mem_wdata[8*i+:8];
            k++;
        end else begin
            act = 0;
            mem_ack = 0;
            mem_rdata = $urandom;
        end
    end

    // Monitor: checks memory-side transactions and pops the scoreboard on every done pulse.
    tx_t  cur;
    exp_t e_m;
    bit   have = 0;
    int   req_run = 0, low_run = 2;
    always @(negedge CLK) begin
        if (!RESET_N) begin
            have = 0;
            req_run = 0;
            low_run = 2;
        end else begin
            if (mem_req) begin
                if (!have) begin
                    chk("req_gap_ok", low_run >= 2, 1);
                    if (tx_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tx actual=1 required=0 t=%0t", $time);
                        cur = '{addr: '0, be: '0, we: 1'b0, wdata: '0};
                    end else cur = tx_q.pop_front();
                    have = 1;
                end
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_be", mem_be, cur.be);
                chk("mem_we", mem_we, cur.we);
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                chk("stall_busy", stall, 1);
                chk("done_busy", done, 0);
                req_run++;
                low_run = 0;
            end else begin
                have = 0;
                low_run++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("rdata", rdata, e_m.rdata);
                    chk("err", err, e_m.err);
                    chk("busy_cycles", req_run, e_m.busy);
                    chk("latency", cyc - e_m.issue, e_m.busy + 1);
                    chk("stall_resp", stall, 0);
                end
                req_run = 0;
            end
        end
    end

    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        logic [31:0] w, a;
        logic [2:0]  f3;
        bit          we;
        int          r, lat, gap;
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_stall", stall, 0);
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            dmem[i] = w;
            for (int j = 0; j < 4; j++) ref_mem[4*i+j] = w[8*j+:8];
        end
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1;
        @(posedge CLK);
        #1;
        issue(1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 2); wait_done();
        issue(1, 3'b010, 32'h0, 32'h0080_0000, 0);        wait_done();
        issue(0, 3'b000, 32'h2, 32'h0, 0);                wait_done();
        issue(0, 3'b100, 32'h2, 32'h0, 0);                wait_done();
        issue(1, 3'b010, 32'h0, 32'h8001_0000, 0);        wait_done();
        issue(0, 3'b001, 32'h2, 32'h0, 0);                wait_done();
        issue(0, 3'b010, 32'h6, 32'h0, 0);                wait_done();
        issue(1, 3'b100, 32'h4, 32'h0, 0);                wait_done();
        issue(0, 3'b010, 32'h10, 32'h0, 1000);            wait_done();
        issue(0, 3'b010, 32'h10, 32'h0, TO - 1);          wait_done();
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) :
                 we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 5) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            r = $urandom_range(0, 19);
            lat = r < 15 ? r % 4 : r < 17 ? TO - 1 : TO + $urandom_range(0, 3);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                req_valid = 0;
                repeat (gap) @(posedge CLK);
                #1;
            end
            issue(we, f3, a, $urandom, lat);
            wait_done();
        end
        issue(0, 3'b010, 32'h20, 32'h0, 1000);
        repeat (5) @(posedge CLK);
        #3;
        RESET_N = 0;
        req_valid = 0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_done", done, 0);
        chk("arst_stall", stall, 0);
        chk("arst_mem_be", mem_be, 0);
        exp_q.delete();
        tx_q.delete();
        lat_q.delete();
        @(posedge CLK);
        #2 RESET_N = 1;
        @(posedge CLK);
        #1;
        issue(1, 3'b010, 32'h8, 32'hDEAD_BEEF, 1); wait_done();
        issue(0, 3'b010, 32'h8, 32'h0, 0);         wait_done();
        req_valid = 0;
        repeat (3) @(negedge CLK);
        chk("queues_empty", exp_q.size() + tx_q.size() + lat_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
Load/store unit between the single-cycle core's datapath (address from ALU result, store data from register read port 2) and data memory.
- Formats RV32I byte/half/word accesses into word-addressed, byte-enabled memory transactions.
- Sign/zero-extends load data.
- Stalls the core while a multi-cycle memory access is outstanding.
- Reports misalignment, illegal funct3 and memory timeout.

Parameters:
- DATA_SIZE, 1024, data memory depth in 32-bit words; AW = $clog2(DATA_SIZE).
- TIMEOUT, 16, maximum cycles waiting for mem_ack before a timeout error; must be ≥ 1.

Ports:
- CLK  in  1  clock; all state rises on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- req_valid  in  1  core requests an access (MemRead|MemWrite); held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  instruction bits [14:12].
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  core must hold PC/request.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  formatted load result; valid when done=1.
- err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid when done=1.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  AW  word address = addr[AW+1:2]; upper bits ignored (wrap).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.
- mem_ack  in  1  memory completes request (one cycle).

Behaviour:
Reset (async, RESET_N=0):
- state=IDLE; mem_req, mem_we, mem_be, done, err, rdata, timeout counter all 0.
- Assertion mid-access drops mem_req immediately; the access is abandoned and never completes.

FSM states: IDLE, BUSY, RESP.
- IDLE, req_valid=0: stay.
- IDLE, req_valid=1, error check on the same cycle:
  - Illegal funct3 → RESP, err=11. Illegal = load 011/110/111; store 1xx or 011.
  - Misaligned → RESP, err=01. Misaligned = half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise → BUSY. Register mem_addr, mem_we=req_we, mem_be, mem_wdata, funct3, addr[1:0]; mem_req=1 from the next cycle.
- BUSY:
  - Hold mem_req and all mem_* outputs stable.
  - Counter increments each cycle.
  - mem_ack=1 → RESP, err=00; on loads, rdata = formatted mem_rdata captured that edge.
  - Counter reaches TIMEOUT-1 without ack → RESP, err=10, rdata=0.
  - mem_ack on the same cycle as timeout expiry: ack wins.
- RESP:
  - done=1 for exactly one cycle, mem_req=0, counter cleared, → IDLE.
  - req_valid is ignored in RESP.
- No memory transaction is issued on error paths.
- Stores return rdata=0.
- stall (combinational) = (IDLE & req_valid) | BUSY; stall=0 in RESP.
- Minimum latency: request cycle → 1 BUSY cycle → RESP, i.e. 3 cycles with zero-wait ack.

Store formatting:
- SB: mem_be = 4'b0001 << addr[1:0]; wdata[7:0] replicated to all 4 lanes.
- SH: mem_be = addr[1] ? 1100 : 0011; wdata[15:0] replicated to both halves.
- SW: mem_be = 1111; wdata passed through.

Load formatting:
- Select lane by addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_be on loads = the same pattern as the equivalent-width store; memory may ignore it.

done, err and rdata hold their values until the next RESP; done itself is a one-cycle pulse.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - err_t enum {ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL}.
  - state_t enum {IDLE, BUSY, RESP}.
- One combinational sub-module lsu_align: store lane/byte-enable generation and load extraction/extension.
- FSM, counter and registers live in lsu_dmem.

Test Plan:
- SB addr=0x0000_0103, wdata=0x1234_56AB, ack after 2 wait cycles → mem_addr=0x40, mem_be=1000, mem_wdata=0xABABABAB; stall high for 4 cycles; done pulse; err=00.
- LB addr=0x2, mem_rdata=0x0080_0000, immediate ack → rdata=0xFFFF_FF80; LBU on the same data → 0x0000_0080; LH addr=0x2 with mem_rdata=0x8001_0000 → 0xFFFF_8001.
- LW addr=0x6 → no mem_req ever asserted; done on the 2nd cycle; err=01. SH with funct3=100 → err=11.
- LW with mem_ack never asserted, TIMEOUT=16 → mem_req high 16 cycles, then done, err=10, rdata=0. mem_ack arriving on the final cycle → err=00.
- RESET_N pulled low during BUSY → mem_req/done/stall fall asynchronously; after release, a new SW addr=0x8 wdata=0xDEADBEEF → mem_be=1111, mem_addr=0x2.
- Back-to-back: req_valid held high across a RESP cycle → second access starts only from IDLE (one idle cycle between mem_req pulses).
